// File: rtl/bram_sys_responder_if.sv
// sys_* command bus shared by SDRAM-style initiators and their memory target.
// The initiator drives command, address and write data; the target answers with ack, strobes and read data.
interface bram_sys_responder_if;
  logic [1:0]  sys_CMD;
  logic [22:0] sys_ADDR;
  logic [15:0] sys_DIN;
  logic [15:0] sys_DOUT;
  logic        sys_rd_data_valid;
  logic        sys_wr_data_valid;
  logic [1:0]  sys_cmd_ack;

  modport master (
    output sys_CMD, sys_ADDR, sys_DIN,
    input  sys_DOUT, sys_rd_data_valid, sys_wr_data_valid, sys_cmd_ack
  );

  modport slave (
    input  sys_CMD, sys_ADDR, sys_DIN,
    output sys_DOUT, sys_rd_data_valid, sys_wr_data_valid, sys_cmd_ack
  );
endinterface

// File: rtl/bram_sys_responder.sv
// Block-RAM target for the sys_* SDRAM command bus: 256 B write, 32 B / 256 B read bursts
// with SDRAM-like ack/strobe timing and optional refresh stalls.
module bram_sys_responder #(
  parameter int MEM_AW       = 14,
  parameter int ACK_DELAY    = 3,
  parameter int DIN_LAT      = 1,
  parameter int REF_INTERVAL = 780,
  parameter int REF_CYCLES   = 8
) (
  input  logic               clk,
  input  logic               rst,
  bram_sys_responder_if.slave sys_if
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACK    = 3'd1,
    LAT    = 3'd2,
    RD     = 3'd3,
    WR     = 3'd4,
    WDRAIN = 3'd5,
    REF    = 3'd6
  } state_t;

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_WR   = 2'b01;
  localparam logic [1:0] CMD_RD32 = 2'b10;

  localparam int CNT_MAX = (REF_CYCLES > 15) ? REF_CYCLES : 15;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int REF_W   = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam int SR_D    = (DIN_LAT > 0) ? DIN_LAT : 1;

  localparam logic [CNT_W-1:0] LAT_LAST   = CNT_W'((ACK_DELAY > 1) ? ACK_DELAY - 2 : 0);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((DIN_LAT > 0) ? DIN_LAT - 1 : 0);
  localparam logic [CNT_W-1:0] REF_LAST   = CNT_W'((REF_CYCLES > 0) ? REF_CYCLES - 1 : 0);
  localparam logic [REF_W-1:0] REF_TOP    = REF_W'((REF_INTERVAL > 0) ? REF_INTERVAL - 1 : 0);

  state_t              state_q, state_d;
  state_t              data_state_s;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [6:0]          beat_q, beat_d;
  logic [6:0]          last_beat_s;
  logic [1:0]          cmd_q, cmd_d;
  logic [MEM_AW-1:0]   base_q, base_d;

  logic [REF_W-1:0]    ref_cnt_q, ref_cnt_d;
  logic                ref_pend_q, ref_pend_d;
  logic                ref_expire_s;
  logic                ref_req_s;

  logic [1:0]          ack_q;
  logic                rd_valid_q;
  logic                wr_valid_q;
  logic [15:0]         dout_q;

  logic [SR_D-1:0]     sr_valid_q;
  logic [6:0]          sr_beat_q [SR_D];

  logic [15:0]         mem_q [2**MEM_AW];
  logic [MEM_AW-1:0]   rd_addr_s;
  logic [MEM_AW-1:0]   wr_addr_s;
  logic [6:0]          wr_beat_s;
  logic                wr_en_s;

  // Refresh timer; an expiry is visible to the FSM in the same cycle so it beats a waiting command.
  always_comb begin
    ref_expire_s = 1'b0;
    ref_cnt_d    = ref_cnt_q;
    if (REF_INTERVAL != 0) begin
      ref_expire_s = (ref_cnt_q == REF_TOP);
      if (ref_expire_s) begin
        ref_cnt_d = {REF_W{1'b0}};
      end else begin
        ref_cnt_d = ref_cnt_q + REF_W'(1'b1);
      end
    end else begin
      ref_cnt_d = {REF_W{1'b0}};
    end
    ref_req_s = ref_pend_q | ref_expire_s;
    if ((state_q == IDLE) && ref_req_s) begin
      ref_pend_d = 1'b0;
    end else begin
      ref_pend_d = ref_req_s;
    end
  end

  // Burst sequencer next-state logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    beat_d       = beat_q;
    cmd_d        = cmd_q;
    base_d       = base_q;
    data_state_s = (cmd_q == CMD_WR) ? WR : RD;
    last_beat_s  = (cmd_q == CMD_RD32) ? 7'd15 : 7'd127;
    case (state_q)
      IDLE: begin
        if (ref_req_s) begin
          state_d = REF;
          cnt_d   = {CNT_W{1'b0}};
        end else if (sys_if.sys_CMD != CMD_NOP) begin
          state_d = ACK;
          cmd_d   = sys_if.sys_CMD;
          base_d  = MEM_AW'({sys_if.sys_ADDR, 1'b0});
        end else begin
          state_d = IDLE;
        end
      end
      ACK: begin
        cnt_d  = {CNT_W{1'b0}};
        beat_d = 7'd0;
        if (ACK_DELAY > 1) begin
          state_d = LAT;
        end else begin
          state_d = data_state_s;
        end
      end
      LAT: begin
        if (cnt_q == LAT_LAST) begin
          state_d = data_state_s;
          beat_d  = 7'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1'b1);
        end
      end
      RD: begin
        if (beat_q == last_beat_s) begin
          state_d = IDLE;
        end else begin
          beat_d = beat_q + 7'd1;
        end
      end
      WR: begin
        if (beat_q == last_beat_s) begin
          cnt_d = {CNT_W{1'b0}};
          if (DIN_LAT > 0) begin
            state_d = WDRAIN;
          end else begin
            state_d = IDLE;
          end
        end else begin
          beat_d = beat_q + 7'd1;
        end
      end
      WDRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1'b1);
        end
      end
      REF: begin
        if (cnt_q == REF_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1'b1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // RAM is addressed with the next beat so the registered read lines up with the valid strobe.
  assign rd_addr_s = base_q + MEM_AW'(beat_d);
  assign wr_beat_s = (DIN_LAT == 0) ? beat_q : sr_beat_q[SR_D-1];
  assign wr_en_s   = (DIN_LAT == 0) ? (state_q == WR) : sr_valid_q[SR_D-1];
  assign wr_addr_s = base_q + MEM_AW'(wr_beat_s);

  // State, refresh and registered bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      beat_q     <= 7'd0;
      cmd_q      <= CMD_NOP;
      base_q     <= {MEM_AW{1'b0}};
      ref_cnt_q  <= {REF_W{1'b0}};
      ref_pend_q <= 1'b0;
      ack_q      <= CMD_NOP;
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      dout_q     <= 16'h0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      cmd_q      <= cmd_d;
      base_q     <= base_d;
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      ack_q      <= (state_d == ACK) ? cmd_d : CMD_NOP;
      rd_valid_q <= (state_d == RD);
      wr_valid_q <= (state_d == WR);
      if (state_d == RD) begin
        dout_q <= mem_q[rd_addr_s];
      end
    end
  end

  // Beat index travels with each strobe until its halfword arrives on sys_DIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SR_D; i++) begin
        sr_valid_q[i] <= 1'b0;
        sr_beat_q[i]  <= 7'd0;
      end
    end else begin
      sr_valid_q[0] <= (state_q == WR);
      sr_beat_q[0]  <= beat_q;
      for (int i = 1; i < SR_D; i++) begin
        sr_valid_q[i] <= sr_valid_q[i-1];
        sr_beat_q[i]  <= sr_beat_q[i-1];
      end
    end
  end

  // Backing RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_addr_s] <= sys_if.sys_DIN;
    end
  end

  assign sys_if.sys_DOUT          = dout_q;
  assign sys_if.sys_rd_data_valid = rd_valid_q;
  assign sys_if.sys_wr_data_valid = wr_valid_q;
  assign sys_if.sys_cmd_ack       = ack_q;

endmodule

// File: tb/tb_bram_sys_responder.sv
// Self-checking bench for bram_sys_responder: table of bursts against a memory model,
// plus hand sequences for refresh collision, mid-burst reset and back-to-back reads.
module tb_bram_sys_responder;
  localparam int MEM_AW       = 14;
  localparam int ACK_DELAY    = 3;
  localparam int DIN_LAT      = 1;
  localparam int REF_INTERVAL = 20;
  localparam int REF_CYCLES   = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bram_sys_responder_if bus ();

  bram_sys_responder #(
    .MEM_AW(MEM_AW), .ACK_DELAY(ACK_DELAY), .DIN_LAT(DIN_LAT),
    .REF_INTERVAL(REF_INTERVAL), .REF_CYCLES(REF_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sys_if(bus)
  );

  typedef struct {
    logic [1:0]  cmd;
    logic [22:0] addr;
    logic [15:0] dbase;
    logic [1:0]  exp_ack;
    int          exp_beats;
  } vec_t;

  vec_t        vecs [7];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [1:0]  ack_exp [$];
  logic [15:0] rd_exp [$];
  logic [15:0] mdl [2**MEM_AW];
  int cyc, ack_cyc, first_beat_cyc, last_beat_cyc;
  int n_acks, n_rd_beats, n_wr_beats, n_rd_total, n_wr_total, wr_beat;
  int hist [4];
  logic [15:0] din_base;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic fail_evt(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got an unexpected event, required none", nm);
  endtask

  // One clock: sample at the falling edge, score outputs, feed write data.
  task automatic tick();
    logic [1:0]  a_exp;
    logic [15:0] d_exp;
    @(negedge clk);
    cyc++;
    chk("valid_exclusive", 32'(bus.sys_rd_data_valid & bus.sys_wr_data_valid), 32'd0);
    if (bus.sys_cmd_ack != 2'b00) begin
      if (ack_exp.size() == 0) begin
        fail_evt("unexpected_ack");
      end else begin
        a_exp = ack_exp.pop_front();
        chk("cmd_ack", 32'(bus.sys_cmd_ack), 32'(a_exp));
      end
      chk("idle_gap_before_ack", 32'(cyc - last_beat_cyc >= 2), 32'd1);
      ack_cyc    = cyc;
      n_acks++;
      n_rd_beats = 0;
      n_wr_beats = 0;
    end
    if (bus.sys_rd_data_valid || bus.sys_wr_data_valid) begin
      if (n_rd_beats + n_wr_beats == 0) first_beat_cyc = cyc;
      last_beat_cyc = cyc;
    end
    if (bus.sys_rd_data_valid) begin
      n_rd_beats++;
      n_rd_total++;
      if (rd_exp.size() == 0) begin
        fail_evt("unexpected_rd_valid");
      end else begin
        d_exp = rd_exp.pop_front();
        chk("rd_data", 32'(bus.sys_DOUT), 32'(d_exp));
      end
    end
    if (bus.sys_wr_data_valid) begin
      n_wr_beats++;
      n_wr_total++;
    end
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = bus.sys_wr_data_valid ? wr_beat : -1;
    if (bus.sys_wr_data_valid) wr_beat++;
    if (hist[DIN_LAT] >= 0) bus.sys_DIN = din_base + 16'(hist[DIN_LAT]);
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_ack_zero"}, 32'(bus.sys_cmd_ack), 32'd0);
    chk({tag, "_rdv_zero"}, 32'(bus.sys_rd_data_valid), 32'd0);
    chk({tag, "_wrv_zero"}, 32'(bus.sys_wr_data_valid), 32'd0);
    chk({tag, "_dout_zero"}, 32'(bus.sys_DOUT), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    last_beat_cyc = -1000;
    ack_exp.delete();
    rd_exp.delete();
    wr_beat = 0;
    n_rd_beats = 0;
    n_wr_beats = 0;
    for (int i = 0; i < 4; i++) hist[i] = -1;
  endtask

  // Issue one burst, predict its ack and data from the model, and check its shape.
  task automatic run_vec(input vec_t v, output int lat);
    logic [23:0]       hw;
    logic [MEM_AW-1:0] a;
    int                n0, start;
    hw = {v.addr, 1'b0};
    for (int k = 0; k < v.exp_beats; k++) begin
      a = hw[MEM_AW-1:0] + MEM_AW'(k);
      if (v.cmd == 2'b01) mdl[a] = v.dbase + 16'(k);
      else rd_exp.push_back(mdl[a]);
    end
    if (v.cmd == 2'b01) begin
      din_base = v.dbase;
      wr_beat  = 0;
    end
    ack_exp.push_back(v.exp_ack);
    n0    = n_acks;
    start = cyc;
    bus.sys_CMD  = v.cmd;
    bus.sys_ADDR = v.addr;
    for (int i = 0; i < 100 && n_acks == n0; i++) tick();
    bus.sys_CMD  = 2'b00;
    bus.sys_ADDR = 23'h7FFFFF;
    chk("ack_once", 32'(n_acks - n0), 32'd1);
    lat = ack_cyc - start;
    for (int i = 0; i < v.exp_beats + ACK_DELAY + DIN_LAT + 4; i++) tick();
    chk("rd_beats", 32'(n_rd_beats), 32'((v.cmd == 2'b01) ? 0 : v.exp_beats));
    chk("wr_beats", 32'(n_wr_beats), 32'((v.cmd == 2'b01) ? v.exp_beats : 0));
    chk("first_beat_delay", 32'(first_beat_cyc - ack_cyc), 32'(ACK_DELAY));
    chk("beats_contiguous", 32'(last_beat_cyc - first_beat_cyc), 32'(v.exp_beats - 1));
    chk("rd_queue_drained", 32'(rd_exp.size()), 32'd0);
  endtask

  initial begin
    int   lat, n0, rd0;
    vec_t hv;

    vecs[0] = '{cmd: 2'b01, addr: 23'h000040, dbase: 16'h0000, exp_ack: 2'b01, exp_beats: 128};
    vecs[1] = '{cmd: 2'b11, addr: 23'h000040, dbase: 16'h0000, exp_ack: 2'b11, exp_beats: 128};
    vecs[2] = '{cmd: 2'b01, addr: 23'h000008, dbase: 16'hA000, exp_ack: 2'b01, exp_beats: 128};
    vecs[3] = '{cmd: 2'b10, addr: 23'h400008, dbase: 16'h0000, exp_ack: 2'b10, exp_beats: 16};
    vecs[4] = '{cmd: 2'b01, addr: 23'h001FF8, dbase: 16'h5000, exp_ack: 2'b01, exp_beats: 128};
    vecs[5] = '{cmd: 2'b11, addr: 23'h001FF8, dbase: 16'h0000, exp_ack: 2'b11, exp_beats: 128};
    vecs[6] = '{cmd: 2'b10, addr: 23'h400008, dbase: 16'h0000, exp_ack: 2'b10, exp_beats: 16};

    n_acks = 0; n_rd_total = 0; n_wr_total = 0; din_base = 16'h0000;
    ack_cyc = 0; first_beat_cyc = 0;
    bus.sys_CMD = 2'b11; bus.sys_ADDR = 23'h0; bus.sys_DIN = 16'h0;
    rst = 1'b1;
    @(negedge clk);
    apply_reset("reset");
    bus.sys_CMD = 2'b00;
    for (int i = 0; i < 100; i++) tick();
    chk("idle_no_ack", 32'(n_acks), 32'd0);
    chk("idle_no_strobes", 32'(n_rd_total + n_wr_total), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], lat);
    // Walking-index data written by the first vector survives where nothing overwrote it.
    chk("model_word_0x90", 32'(mdl[14'h0090]), 32'h0010);

    // Command raised in the very cycle the refresh counter expires.
    apply_reset("ref_reset");
    for (int i = 0; i < REF_INTERVAL - 1; i++) tick();
    hv = '{cmd: 2'b11, addr: 23'h000040, dbase: 16'h0000, exp_ack: 2'b11, exp_beats: 128};
    run_vec(hv, lat);
    chk("ref_ack_latency", 32'(lat), 32'(REF_CYCLES + 2));

    // Reset asserted during write strobe 50.
    hv = '{cmd: 2'b01, addr: 23'h000100, dbase: 16'h1100, exp_ack: 2'b01, exp_beats: 128};
    run_vec(hv, lat);
    din_base = 16'h2200;
    wr_beat  = 0;
    ack_exp.push_back(2'b01);
    n0 = n_acks;
    bus.sys_CMD = 2'b01; bus.sys_ADDR = 23'h000100;
    for (int i = 0; i < 100 && n_acks == n0; i++) tick();
    bus.sys_CMD = 2'b00;
    chk("mb_ack_once", 32'(n_acks - n0), 32'd1);
    for (int i = 0; i < 300 && wr_beat < 51; i++) tick();
    chk("mb_reached_beat50", 32'(wr_beat), 32'd51);
    apply_reset("midburst");
    for (int k = 0; k < 50 - DIN_LAT; k++) mdl[14'h0200 + 14'(k)] = 16'h2200 + 16'(k);
    hv = '{cmd: 2'b11, addr: 23'h000100, dbase: 16'h0000, exp_ack: 2'b11, exp_beats: 128};
    run_vec(hv, lat);

    // Read-32 held continuously for three bursts.
    for (int r = 0; r < 3; r++) begin
      ack_exp.push_back(2'b10);
      for (int k = 0; k < 16; k++) rd_exp.push_back(mdl[14'h0080 + 14'(k)]);
    end
    n0  = n_acks;
    rd0 = n_rd_total;
    bus.sys_CMD = 2'b10; bus.sys_ADDR = 23'h000040;
    for (int i = 0; i < 400 && n_acks < n0 + 3; i++) tick();
    bus.sys_CMD = 2'b00;
    for (int i = 0; i < 30; i++) tick();
    chk("b2b_acks", 32'(n_acks - n0), 32'd3);
    chk("b2b_rd_valids", 32'(n_rd_total - rd0), 32'd48);
    chk("b2b_last_burst_len", 32'(n_rd_beats), 32'd16);
    chk("b2b_queue_drained", 32'(rd_exp.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
